// File: rtl/wb_stage.sv
// wb_stage: writeback register, load-data formatting and the single GPR write
// port, shared with long-latency results queued in a small FIFO.
// Optional feature macro: YT_WB_SUBWORD_LOAD_EN (enables LH/LHU/LB/LBU extraction;
// without it every load writes the raw memory word).
module wb_stage #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_mem_valid,
    input  logic        i_mem_we,
    input  logic [4:0]  i_mem_waddr,
    input  logic [31:0] i_mem_result,
    input  logic        i_mem_is_load,
    input  logic [2:0]  i_mem_load_type,
    input  logic [1:0]  i_mem_byte_off,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_lr_valid,
    output logic        o_lr_ready,
    input  logic [4:0]  i_lr_waddr,
    input  logic [31:0] i_lr_wdata,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic [31:0] o_pending_mask
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic        is_load;
        logic [2:0]  load_type;
        logic [1:0]  byte_off;
        logic [31:0] result;
        logic [31:0] rdata;
        logic        done;
    } wb_reg_t;

    wb_reg_t           wb;
    logic              pipe_req;
    logic [31:0]       load_data;
    logic [31:0]       wb_data;

    logic [4:0]        fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // done blocks a second write while a stalled instruction sits in WB
    assign pipe_req = !reset && wb.valid && wb.we && (wb.waddr != 5'd0) && !wb.done;

    // WB register: reset > flush > stall (hold, remember the write) > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            wb <= '0;
        end else if (i_flush) begin
            wb.valid <= 1'b0;
        end else if (i_stall) begin
            if (pipe_req) wb.done <= 1'b1;
        end else begin
            wb.valid     <= i_mem_valid;
            wb.we        <= i_mem_we;
            wb.waddr     <= i_mem_waddr;
            wb.is_load   <= i_mem_is_load;
            wb.load_type <= i_mem_load_type;
            wb.byte_off  <= i_mem_byte_off;
            wb.result    <= i_mem_result;
            wb.rdata     <= i_mem_rdata;
            wb.done      <= 1'b0;
        end
    end

`ifdef YT_WB_SUBWORD_LOAD_EN
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // little-endian sub-word extraction with sign/zero extension
    always_comb begin
        ld_half = wb.byte_off[1] ? wb.rdata[31:16] : wb.rdata[15:0];
        unique case (wb.byte_off)
            2'd0:    ld_byte = wb.rdata[7:0];
            2'd1:    ld_byte = wb.rdata[15:8];
            2'd2:    ld_byte = wb.rdata[23:16];
            default: ld_byte = wb.rdata[31:24];
        endcase
        case (wb.load_type)
            3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
            3'd2:    load_data = {16'd0, ld_half};
            3'd3:    load_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    load_data = {24'd0, ld_byte};
            default: load_data = wb.rdata;
        endcase
    end
`else
    // sub-word support compiled out: the type/offset fields are carried but ignored
    logic unused_ld_fields;
    assign unused_ld_fields = ^{wb.load_type, wb.byte_off};
    assign load_data = wb.rdata;
`endif

    assign wb_data = wb.is_load ? load_data : wb.result;

    // ready depends only on the registered count, so a same-cycle pop never raises it
    assign o_lr_ready = !reset && (count < CNT_W'(FIFO_DEPTH));
    assign push       = i_lr_valid && o_lr_ready && (i_lr_waddr != 5'd0);
    assign pop        = !reset && !pipe_req && (count != '0);

    // FIFO payload storage, written only on a real push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_lr_waddr;
            fifo_data[wr_ptr] <= i_lr_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // write port: pipeline first, otherwise drain the FIFO head, otherwise all zero
    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = 5'd0;
        o_rf_wdata = 32'd0;
        if (pipe_req) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = wb.waddr;
            o_rf_wdata = wb_data;
        end else if (pop) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = fifo_addr[rd_ptr];
            o_rf_wdata = fifo_data[rd_ptr];
        end
    end

    // pending mask: an entry is live if its distance from the head is below count
    always_comb begin
        logic [PTR_W-1:0] off;
        off            = '0;
        o_pending_mask = 32'd0;
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                off = PTR_W'(i) - rd_ptr;
                if ({1'b0, off} < count) o_pending_mask[fifo_addr[i]] = 1'b1;
            end
        end
    end
endmodule
